// File: rtl/payload_match_engine.sv
// Payload match engine: step-vector matcher for a class-sequence pattern with optional "+" steps.
// Define PAYLOAD_ENGINE_POS_CAPTURE_EN to build the byte-offset counter and match_pos capture.
module payload_match_engine #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned NUM_CLASS = 32,
    localparam int unsigned CLS_W = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1,
    parameter logic [DEPTH*CLS_W-1:0] STEP_CLASS = '0,
    parameter logic [DEPTH-1:0] REPEAT_MASK = '0,
    parameter bit ANCHORED = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 sod,
    input  logic [NUM_CLASS-1:0] cls_hit,
    output logic                 match,
    output logic                 match_pulse,
    output logic [7:0]           match_cnt,
    output logic [15:0]          match_pos
);

    logic [DEPTH-1:0] s_q, s_d;
    logic [DEPTH-1:0] hit;
    logic [DEPTH-1:0] s_old;
    logic [DEPTH-1:0] s_new;
    logic             start;
    logic             end_hit;

    logic             match_q, match_d;
    logic             pulse_q, pulse_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             base_match;
    logic [7:0]       base_cnt;

    // Steps naming a class beyond NUM_CLASS can never hit.
    always_comb begin
        hit = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (32'(STEP_CLASS[i*CLS_W +: CLS_W]) < NUM_CLASS) begin
                hit[i] = cls_hit[STEP_CLASS[i*CLS_W +: CLS_W]];
            end
        end
    end

    always_comb begin
        start    = ANCHORED ? sod : 1'b1;
        s_old    = sod ? '0 : s_q;
        s_new    = '0;
        s_new[0] = hit[0] & (start | (REPEAT_MASK[0] & s_old[0]));
        for (int i = 1; i < int'(DEPTH); i++) begin
            s_new[i] = hit[i] & (s_old[i-1] | (REPEAT_MASK[i] & s_old[i]));
        end
        end_hit = en & s_new[DEPTH-1];
        s_d     = en ? s_new : s_q;
    end

    // An sod byte clears the sticky results before its own evaluation.
    always_comb begin
        base_match = sod ? 1'b0 : match_q;
        base_cnt   = sod ? 8'd0 : cnt_q;
        match_d    = match_q;
        cnt_d      = cnt_q;
        pulse_d    = 1'b0;
        if (en) begin
            match_d = base_match | end_hit;
            pulse_d = end_hit & ~base_match;
            cnt_d   = base_cnt;
            if (end_hit && base_cnt != 8'hFF) begin
                cnt_d = base_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q     <= '0;
            match_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            s_q     <= s_d;
            match_q <= match_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PAYLOAD_ENGINE_POS_CAPTURE_EN
    logic [15:0] off_q, off_d;
    logic [15:0] pos_q, pos_d;
    logic [15:0] cur_off;
    logic [15:0] base_pos;

    // off_q holds the offset the next accepted byte will carry.
    always_comb begin
        cur_off  = sod ? 16'd0 : off_q;
        base_pos = sod ? 16'd0 : pos_q;
        off_d    = off_q;
        pos_d    = pos_q;
        if (en) begin
            off_d = (cur_off == 16'hFFFF) ? cur_off : cur_off + 16'd1;
            pos_d = (end_hit && !base_match) ? cur_off : base_pos;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            off_q <= 16'd0;
            pos_q <= 16'd0;
        end else begin
            off_q <= off_d;
            pos_q <= pos_d;
        end
    end

    assign match_pos = pos_q;
`else
    assign match_pos = 16'd0;
`endif

    assign match       = match_q;
    assign match_pulse = pulse_q;
    assign match_cnt   = cnt_q;

endmodule

// File: tb/tb_payload_match_engine.sv
// Bench for payload_match_engine: three configurations driven by one stream, checked against
// a regex-level model of the patterns "^c0 c1+ c2", "c0 c1+ c2" and "c0".
module tb_payload_match_engine;

    localparam int NC = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          sod;
    logic [NC-1:0] cls_hit;

    logic          m_o [3];
    logic          p_o [3];
    logic [7:0]    cnt_o [3];
    logic [15:0]   pos_o [3];

    int ncmp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    payload_match_engine #(
        .DEPTH(3), .NUM_CLASS(NC), .STEP_CLASS(6'b10_01_00), .REPEAT_MASK(3'b010), .ANCHORED(1'b1)
    ) u_anch (
        .clk(clk), .rst_n(rst_n), .en(en), .sod(sod), .cls_hit(cls_hit),
        .match(m_o[0]), .match_pulse(p_o[0]), .match_cnt(cnt_o[0]), .match_pos(pos_o[0])
    );

    payload_match_engine #(
        .DEPTH(3), .NUM_CLASS(NC), .STEP_CLASS(6'b10_01_00), .REPEAT_MASK(3'b010), .ANCHORED(1'b0)
    ) u_float (
        .clk(clk), .rst_n(rst_n), .en(en), .sod(sod), .cls_hit(cls_hit),
        .match(m_o[1]), .match_pulse(p_o[1]), .match_cnt(cnt_o[1]), .match_pos(pos_o[1])
    );

    payload_match_engine #(
        .DEPTH(1), .NUM_CLASS(NC), .STEP_CLASS(2'b00), .REPEAT_MASK(1'b0), .ANCHORED(1'b0)
    ) u_single (
        .clk(clk), .rst_n(rst_n), .en(en), .sod(sod), .cls_hit(cls_hit),
        .match(m_o[2]), .match_pulse(p_o[2]), .match_cnt(cnt_o[2]), .match_pos(pos_o[2])
    );

    // Model state: bytes of the current segment plus expected outputs per configuration.
    logic [NC-1:0] hist [$];
    bit            seg_sod;
    bit            exp_m [3];
    bit            exp_p [3];
    int            exp_cnt [3];
    int            exp_pos [3];

    // Does a match of configuration c end on segment byte j?
    function automatic bit ends_here(int c, int j);
        if (c == 2) return hist[j][0];
        if (j < 2 || !hist[j][2]) return 1'b0;
        for (int m = j - 1; m >= 1; m--) begin
            if (!hist[m][1]) return 1'b0;
            if (hist[m-1][0] && (c == 1 || (seg_sod && m == 1))) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_update(bit r, bit e, bit s, logic [NC-1:0] cl);
        int j;
        for (int c = 0; c < 3; c++) exp_p[c] = 1'b0;
        if (!r) begin
            hist.delete();
            seg_sod = 1'b0;
            for (int c = 0; c < 3; c++) begin
                exp_m[c] = 1'b0; exp_cnt[c] = 0; exp_pos[c] = 0;
            end
        end else if (e) begin
            if (s) begin
                hist.delete();
                seg_sod = 1'b1;
                for (int c = 0; c < 3; c++) begin
                    exp_m[c] = 1'b0; exp_cnt[c] = 0; exp_pos[c] = 0;
                end
            end
            hist.push_back(cl);
            j = hist.size() - 1;
            for (int c = 0; c < 3; c++) begin
                if (ends_here(c, j)) begin
                    if (!exp_m[c]) begin
                        exp_p[c]   = 1'b1;
                        exp_pos[c] = (j > 65535) ? 65535 : j;
                    end
                    exp_m[c]   = 1'b1;
                    exp_cnt[c] = (exp_cnt[c] < 255) ? exp_cnt[c] + 1 : 255;
                end
            end
        end
    endtask

    task automatic chk(string tag, int c, logic [15:0] act, logic [15:0] exp);
        ncmp++;
        assert (act === exp)
        else begin
            nfail++;
            $error("FAIL %s[%0d] at %0t: observed %0h expected %0h", tag, c, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] pos_expect(int c);
`ifdef PAYLOAD_ENGINE_POS_CAPTURE_EN
        return 16'(exp_pos[c]);
`else
        return 16'd0;
`endif
    endfunction

    task automatic check_all();
        for (int c = 0; c < 3; c++) begin
            chk("match", c, 16'(m_o[c]), 16'(exp_m[c]));
            chk("match_pulse", c, 16'(p_o[c]), 16'(exp_p[c]));
            chk("match_cnt", c, 16'(cnt_o[c]), 16'(exp_cnt[c]));
            chk("match_pos", c, pos_o[c], pos_expect(c));
        end
    endtask

    task automatic cyc(bit r, bit e, bit s, logic [NC-1:0] cl);
        rst_n = r; en = e; sod = s; cls_hit = cl;
        @(posedge clk);
        model_update(r, e, s, cl);
        #1 check_all();
    endtask

    task automatic gap(int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 4'b0000);
    endtask

    int pulses;
    logic [NC-1:0] rc;

    initial begin
        rst_n = 1'b0; en = 1'b0; sod = 1'b0; cls_hit = '0;
        // Reset overrides en and sod.
        cyc(1'b0, 1'b1, 1'b1, 4'b1111);
        cyc(1'b0, 1'b0, 1'b0, 4'b0000);

        // Test 1: ^ c0 c1 c1 c2
        cyc(1'b1, 1'b1, 1'b1, 4'b0001);
        cyc(1'b1, 1'b1, 1'b0, 4'b0010);
        cyc(1'b1, 1'b1, 1'b0, 4'b0010);
        cyc(1'b1, 1'b1, 1'b0, 4'b0100);
        chk("t1_pulse", 0, 16'(p_o[0]), 16'd1);
        chk("t1_cnt", 0, 16'(cnt_o[0]), 16'd1);
        gap(2);
        chk("t1_match", 0, 16'(m_o[0]), 16'd1);

        // Test 2: c2 c0 c1 c2 never matches anchored, matches floating at offset 3.
        cyc(1'b1, 1'b1, 1'b1, 4'b0100);
        cyc(1'b1, 1'b1, 1'b0, 4'b0001);
        cyc(1'b1, 1'b1, 1'b0, 4'b0010);
        cyc(1'b1, 1'b1, 1'b0, 4'b0100);
        gap(1);
        chk("t2_anch", 0, 16'(m_o[0]), 16'd0);
        chk("t2_float", 1, 16'(m_o[1]), 16'd1);

        // Test 3: Test 1 with two-cycle en gaps; count pulses on the anchored unit.
        pulses = 0;
        cyc(1'b1, 1'b1, 1'b1, 4'b0001); gap(2);
        cyc(1'b1, 1'b1, 1'b0, 4'b0010); gap(2);
        cyc(1'b1, 1'b1, 1'b0, 4'b0010); gap(2);
        cyc(1'b1, 1'b1, 1'b0, 4'b0100); pulses += int'(p_o[0]);
        for (int i = 0; i < 4; i++) begin
            gap(1);
            pulses += int'(p_o[0]);
        end
        chk("t3_pulses", 0, 16'(pulses), 16'd1);

        // Test 4: sod restarts progress and clears the previous match.
        cyc(1'b1, 1'b1, 1'b1, 4'b0001);
        cyc(1'b1, 1'b1, 1'b0, 4'b0010);
        cyc(1'b1, 1'b1, 1'b1, 4'b0010);
        cyc(1'b1, 1'b1, 1'b0, 4'b0100);
        gap(1);
        chk("t4_match", 0, 16'(m_o[0]), 16'd0);

        // Test 5: reset mid-match discards progress.
        cyc(1'b1, 1'b1, 1'b1, 4'b0001);
        cyc(1'b1, 1'b1, 1'b0, 4'b0010);
        cyc(1'b0, 1'b1, 1'b0, 4'b0010);
        cyc(1'b1, 1'b1, 1'b0, 4'b0100);
        gap(1);

        // Test 6: 300 class-0 bytes saturate the single-step counter.
        cyc(1'b1, 1'b1, 1'b1, 4'b0001);
        for (int i = 0; i < 300; i++) cyc(1'b1, 1'b1, 1'b0, 4'b0001);
        chk("t6_cnt", 2, 16'(cnt_o[2]), 16'd255);
        chk("t6_pos", 2, pos_o[2], 16'd0);

        // Random traffic with occasional sod, idle and reset.
        for (int i = 0; i < 600; i++) begin
            rc = 4'(1 << $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) rc = rc | 4'($urandom);
            cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) < 8),
                ($urandom_range(0, 7) == 0), rc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/payload_match_engine.md
PAYLOAD_MATCH_ENGINE -- requirements
Module: payload_match_engine

Interface
REQ-001 Parameter DEPTH, default 16: number of pattern steps, legal range 1..64.
REQ-002 Parameter NUM_CLASS, default 32: number of character-class decode lines, legal range 1..256; CLS_W = max(1, clog2(NUM_CLASS)).
REQ-003 Parameter STEP_CLASS, default all zeros, width DEPTH*CLS_W: class index per step; step i occupies bits [i*CLS_W +: CLS_W].
REQ-004 Parameter REPEAT_MASK, default 0, width DEPTH: bit i=1 means step i may repeat (the "+" quantifier).
REQ-005 Parameter ANCHORED, default 1: 1 = match only from first payload byte (^), 0 = match from any byte.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst_n  input  1  synchronous, active-low reset.
REQ-008 en  input  1  byte-valid qualifier; one payload byte is consumed per clk with en=1.
REQ-009 sod  input  1  start-of-data marker; coincides with the first byte of a payload; ignored when en=0.
REQ-010 cls_hit  input  NUM_CLASS  class decode for the current byte; bit k=1 means the byte belongs to class k.
REQ-011 match  output  1  sticky: pattern matched since last sod.
REQ-012 match_pulse  output  1  one-clock pulse on the 0->1 transition of match.
REQ-013 match_cnt  output  8  number of bytes that ended a match since sod; saturates at 255.
REQ-014 match_pos  output  16  byte offset (0 = sod byte) of the final byte of the first match.

Function
REQ-015 The block SHALL keep a DEPTH-bit step vector s; hit[i] = cls_hit[STEP_CLASS[i]].
REQ-016 On each accepted byte, the block SHALL update s[i] <= hit[i] & (prev[i] | (REPEAT_MASK[i] & s_old[i])), where prev[0]=start and prev[i]=s_old[i-1].
REQ-017 The block SHALL treat s_old as all zeros on a byte with sod=1.
REQ-018 The block SHALL use start = sod for ANCHORED=1 and start = 1 for ANCHORED=0.
REQ-019 The block SHALL define end_hit as the newly computed value of s[DEPTH-1] on an accepted byte.
REQ-020 The block SHALL set match, match_cnt and match_pos on the same edge that accepts the final byte, so they are visible one clock after that byte.
REQ-021 On an sod byte, the block SHALL clear match, match_cnt and match_pos before evaluating that byte; a DEPTH=1 match on the sod byte SHALL still register.
REQ-022 The block SHALL count byte offset 0 on the sod byte, increment it per accepted byte, and saturate it at 0xFFFF.
REQ-023 match_pos SHALL capture the offset only on the first end_hit after sod, and SHALL hold thereafter.
REQ-024 match_cnt SHALL increment on every end_hit, including overlapping matches and repeat-extended matches, and SHALL stay at 255 once reached.
REQ-025 With en=0, all state SHALL hold and match_pulse SHALL be 0.
REQ-026 Bytes accepted before any sod since reset SHALL be processed with ANCHORED=0 semantics only when ANCHORED=0; with ANCHORED=1 they never match.

Reset
REQ-027 With rst_n=0 at a clock edge, s, the offset counter, match, match_pulse, match_cnt and match_pos SHALL all become 0, overriding en and sod.
REQ-028 Reset asserted mid-match SHALL discard the partial progress; no match SHALL result from bytes straddling the reset.

Configuration
REQ-029 Macro PAYLOAD_ENGINE_POS_CAPTURE_EN defined: the offset counter and match_pos logic SHALL be built as specified.
REQ-030 Macro PAYLOAD_ENGINE_POS_CAPTURE_EN undefined: the offset counter SHALL be omitted and match_pos SHALL be tied to 0; all other behaviour SHALL be unchanged.

Verification
Bench configuration unless stated: DEPTH=3, STEP_CLASS={0,1,2}, REPEAT_MASK=3'b010, ANCHORED=1, macro defined.
REQ-031 Test 1: sod+class0, then class1, class1, class2 -> match=1 and a single match_pulse one clock after the 4th byte; match_cnt=1; match_pos=3.
REQ-032 Test 2: sod+class2, then class0, class1, class2 -> match=0. The same stream with ANCHORED=0 -> match=1, match_pos=3.
REQ-033 Test 3: Test 1 stream with en=0 gaps of 2 cycles between bytes -> identical outputs; match_pulse high exactly one clock.
REQ-034 Test 4: sod+class0, class1, then sod+class1, class2 -> match=0, and match stays cleared from the Test 1 result.
REQ-035 Test 5: sod+class0, class1, rst_n=0 for one clock, then class2 -> all outputs 0 throughout.
REQ-036 Test 6: DEPTH=1, class0, ANCHORED=0, sod then 300 class0 bytes -> match_cnt=255, match_pos=0. The same run with the macro undefined -> match_pos=0 and match_cnt=255.
